calc_nport: RTL and testbench

CALC_NPORT -- requirements
Module: calc_nport

---
 rtl/calc_pkg.sv | 21 ++
 rtl/calc_alu.sv | 57 +++++
 rtl/calc_nport.sv | 117 +++++++++++
 tb/tb_calc_nport.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: command codes, response codes and per-port state encoding
// shared by the calc_nport request/response calculator and its ALU.
package calc_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_WAIT = 2'd2
  } port_state_t;

endpackage

// File: rtl/calc_alu.sv
// calc_alu: combinational ALU shared by all ports of calc_nport.
// Optional feature macro: CALC_SHIFT_EN enables the shift commands; without
// it the shift codes fall into the invalid-command path and no shifter exists.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [1:0]        resp,
  output logic [DATA_W-1:0] data
);

`ifdef CALC_SHIFT_EN
  localparam int SH_W = $clog2(DATA_W);
`endif

  logic [DATA_W:0] sum;

  // Decode the command; anything not explicitly handled reports an error with zero data.
  always_comb begin
    resp = RESP_ERR;
    data = '0;
    sum  = {1'b0, op1} + {1'b0, op2};
    case (cmd)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          resp = RESP_OK;
          data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          resp = RESP_OK;
          data = op1 - op2;
        end
      end
`ifdef CALC_SHIFT_EN
      CMD_SHL: begin
        resp = RESP_OK;
        data = op1 << op2[SH_W-1:0];
      end
      CMD_SHR: begin
        resp = RESP_OK;
        data = op1 >> op2[SH_W-1:0];
      end
`endif
      default: begin
        resp = RESP_ERR;
        data = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc_nport.sv
// calc_nport: N independent two-cycle request ports sharing one ALU through
// a round-robin arbiter; each result is registered and shown for one cycle.
// Optional feature macro: CALC_SHIFT_EN (passed through to calc_alu).
module calc_nport
  import calc_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [N_PORTS*4-1:0]        req_cmd_in,
  input  logic [N_PORTS*DATA_W-1:0]   req_data_in,
  output logic [N_PORTS*2-1:0]        out_resp,
  output logic [N_PORTS*DATA_W-1:0]   out_data
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  port_state_t       state_q [N_PORTS];
  port_state_t       state_d [N_PORTS];
  logic [3:0]        cmd_q   [N_PORTS];
  logic [DATA_W-1:0] op1_q   [N_PORTS];
  logic [DATA_W-1:0] op2_q   [N_PORTS];
  logic [1:0]        resp_q  [N_PORTS];
  logic [DATA_W-1:0] data_q  [N_PORTS];

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand;
  logic              grant_valid;
  logic [1:0]        alu_resp;
  logic [DATA_W-1:0] alu_data;

  // Round-robin pick of one waiting port, searching upward from rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % N_PORTS);
      if (!grant_valid && state_q[cand] == ST_WAIT) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Per-port next state: capture op1, then op2, then wait for an ALU grant.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      state_d[p] = state_q[p];
      case (state_q[p])
        ST_IDLE: if (req_cmd_in[4*p +: 4] != CMD_NOP) state_d[p] = ST_OP2;
        ST_OP2:  state_d[p] = ST_WAIT;
        ST_WAIT: if (grant_valid && grant_idx == PTR_W'(p)) state_d[p] = ST_IDLE;
        default: state_d[p] = ST_IDLE;
      endcase
    end
  end

  // Port state register.
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (reset) state_q[p] <= ST_IDLE;
      else       state_q[p] <= state_d[p];
    end
  end

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd  (cmd_q[grant_idx]),
    .op1  (op1_q[grant_idx]),
    .op2  (op2_q[grant_idx]),
    .resp (alu_resp),
    .data (alu_data)
  );

  // Operand capture, arbiter pointer and registered one-cycle responses.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        cmd_q[p]  <= CMD_NOP;
        op1_q[p]  <= '0;
        op2_q[p]  <= '0;
        resp_q[p] <= RESP_NONE;
        data_q[p] <= '0;
      end
    end else begin
      if (grant_valid) begin
        rr_ptr <= (grant_idx == PTR_W'(N_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      for (int p = 0; p < N_PORTS; p++) begin
        if (state_q[p] == ST_IDLE && req_cmd_in[4*p +: 4] != CMD_NOP) begin
          cmd_q[p] <= req_cmd_in[4*p +: 4];
          op1_q[p] <= req_data_in[DATA_W*p +: DATA_W];
        end
        if (state_q[p] == ST_OP2) begin
          op2_q[p] <= req_data_in[DATA_W*p +: DATA_W];
        end
        if (grant_valid && grant_idx == PTR_W'(p)) begin
          resp_q[p] <= alu_resp;
          data_q[p] <= alu_data;
        end else begin
          resp_q[p] <= RESP_NONE;
          data_q[p] <= '0;
        end
      end
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_pack
    assign out_resp[2*p +: 2]           = resp_q[p];
    assign out_data[DATA_W*p +: DATA_W] = data_q[p];
  end

endmodule

// File: tb/tb_calc_nport.sv
// tb_calc_nport: directed and randomized checks of calc_nport (4x32 build)
// plus a small 2x8 build for the narrow-width overflow boundary.
module tb_calc_nport;
  import calc_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;

  logic              c_clk = 1'b0;
  logic              reset;
  logic [NP*4-1:0]   req_cmd_in;
  logic [NP*DW-1:0]  req_data_in;
  logic [NP*2-1:0]   out_resp;
  logic [NP*DW-1:0]  out_data;

  logic [7:0]        cmd8;
  logic [15:0]       data8;
  logic [3:0]        resp8;
  logic [15:0]       odata8;

  int checks = 0;
  int errors = 0;

  // model state for the randomized phase
  bit              busy    [NP];
  bit              op2_due [NP];
  int              ready   [NP];
  logic [3:0]      mc      [NP];
  logic [DW-1:0]   ma      [NP];
  logic [DW-1:0]   mb      [NP];
  logic [1:0]      er      [NP];
  logic [DW-1:0]   ed      [NP];
  int              rr;
  int              g;
  int              q;

  always #5 c_clk = ~c_clk;

  calc_nport #(.N_PORTS(NP), .DATA_W(DW)) u_dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data)
  );

  calc_nport #(.N_PORTS(2), .DATA_W(8)) u_dut8 (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (cmd8),
    .req_data_in (data8),
    .out_resp    (resp8),
    .out_data    (odata8)
  );

  task automatic nextCycle();
    @(posedge c_clk);
    #1;
  endtask

  task automatic applyStimulus(input int p, input logic [3:0] cmd, input logic [DW-1:0] d);
    req_cmd_in[4*p +: 4]   = cmd;
    req_data_in[DW*p +: DW] = d;
  endtask

  task automatic idleAll();
    req_cmd_in  = '0;
    req_data_in = '0;
  endtask

  task automatic checkOutput(input string tag, input int p, input logic [1:0] xr, input logic [DW-1:0] xd);
    logic [1:0]    r;
    logic [DW-1:0] d;
    r = out_resp[2*p +: 2];
    d = out_data[DW*p +: DW];
    checks++;
    assert ({r, d} === {xr, xd}) else begin
      errors++;
      $error("[TB] FAIL %s port%0d: observed resp=%0d data=%h, expected resp=%0d data=%h",
             tag, p, r, d, xr, xd);
    end
  endtask

  task automatic checkQuiet(input string tag);
    for (int p = 0; p < NP; p++) checkOutput(tag, p, RESP_NONE, '0);
  endtask

  task automatic check8(input string tag, input int p, input logic [1:0] xr, input logic [7:0] xd);
    logic [1:0] r;
    logic [7:0] d;
    r = resp8[2*p +: 2];
    d = odata8[8*p +: 8];
    checks++;
    assert ({r, d} === {xr, xd}) else begin
      errors++;
      $error("[TB] FAIL %s port%0d: observed resp=%0d data=%h, expected resp=%0d data=%h",
             tag, p, r, d, xr, xd);
    end
  endtask

  // Arithmetic meaning of each command, written from the command definitions.
  function automatic void refCalc(input logic [3:0] cmd, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, output logic [1:0] r,
                                  output logic [DW-1:0] d);
    logic [63:0] s;
    r = RESP_ERR;
    d = '0;
    case (cmd)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s < 64'h1_0000_0000) begin r = RESP_OK; d = DW'(s); end
      end
      4'd2: if (b <= a) begin r = RESP_OK; d = a - b; end
`ifdef CALC_SHIFT_EN
      4'd5: begin r = RESP_OK; d = a << (b % DW); end
      4'd6: begin r = RESP_OK; d = a >> (b % DW); end
`endif
      default: begin r = RESP_ERR; d = '0; end
    endcase
  endfunction

  function automatic logic [DW-1:0] rndOp();
    case ($urandom % 4)
      0:       return DW'($urandom % 16);
      1:       return 32'hFFFF_FFF0 | DW'($urandom % 16);
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] rndCmd();
    case ($urandom % 6)
      0:       return 4'd1;
      1:       return 4'd2;
      2:       return 4'd5;
      3:       return 4'd6;
      default: return 4'(($urandom % 15) + 1);
    endcase
  endfunction

  // Single request on one port while the others stay idle; ends in the response cycle.
  task automatic runOp(input int p, input logic [3:0] cmd, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [1:0] xr,
                       input logic [DW-1:0] xd, input string tag);
    applyStimulus(p, cmd, a);
    nextCycle();
    applyStimulus(p, 4'd0, b);
    checkOutput({tag, "_t1"}, p, RESP_NONE, '0);
    nextCycle();
    applyStimulus(p, 4'd0, '0);
    checkOutput({tag, "_t2"}, p, RESP_NONE, '0);
    nextCycle();
    checkOutput(tag, p, xr, xd);
  endtask

  // All ports add (p+1)+1 at once; responses expected one per cycle from port 'first'.
  task automatic runBurst(input int first, input string tag);
    int w;
    for (int p = 0; p < NP; p++) applyStimulus(p, 4'd1, DW'(p + 1));
    nextCycle();
    for (int p = 0; p < NP; p++) applyStimulus(p, 4'd0, DW'(1));
    checkQuiet({tag, "_t1"});
    nextCycle();
    idleAll();
    checkQuiet({tag, "_t2"});
    for (int k = 0; k < NP; k++) begin
      nextCycle();
      w = (first + k) % NP;
      for (int p = 0; p < NP; p++) begin
        if (p == w) checkOutput(tag, p, RESP_OK, DW'(p + 2));
        else        checkOutput(tag, p, RESP_NONE, '0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idleAll();
    cmd8  = '0;
    data8 = '0;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    checkQuiet("reset_state");

    runOp(0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, RESP_OK, 32'h0200_0000, "add_basic");
    runOp(0, 4'd1, 32'hFFFF_FFFF, 32'h1, RESP_ERR, '0, "add_carry");
    runOp(0, 4'd2, 32'h1, 32'hF, RESP_ERR, '0, "sub_under");
    runOp(0, 4'd2, 32'h7, 32'h7, RESP_OK, '0, "sub_equal");
    runOp(3, 4'd2, 32'h9, 32'h4, RESP_OK, 32'h5, "sub_basic");
    runOp(2, 4'd3, 32'h1, 32'h1, RESP_ERR, '0, "cmd3_invalid");
    runOp(2, 4'd4, 32'h1, 32'h1, RESP_ERR, '0, "cmd4_invalid");
`ifdef CALC_SHIFT_EN
    runOp(2, 4'd5, 32'h1, 32'h4, RESP_OK, 32'h10, "shl");
    runOp(2, 4'd6, 32'h8000_0000, 32'h2F, RESP_OK, 32'h0001_0000, "shr");
`else
    runOp(2, 4'd5, 32'h1, 32'h4, RESP_ERR, '0, "shl_disabled");
    runOp(2, 4'd6, 32'h8000_0000, 32'h2F, RESP_ERR, '0, "shr_disabled");
`endif

    // command during WAIT is dropped: exactly one response
    applyStimulus(1, 4'd1, 32'h5);
    nextCycle();
    applyStimulus(1, 4'd0, 32'h6);
    nextCycle();
    applyStimulus(1, 4'd1, 32'h9);
    nextCycle();
    applyStimulus(1, 4'd0, '0);
    checkOutput("wait_ignore_resp", 1, RESP_OK, 32'hB);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput("wait_ignore_extra", 1, RESP_NONE, '0);
    end

    // reset during the OP2 cycle aborts the request
    applyStimulus(1, 4'd1, 32'h5);
    nextCycle();
    applyStimulus(1, 4'd0, 32'h6);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    idleAll();
    checkQuiet("reset_op2_t2");
    nextCycle();
    checkQuiet("reset_op2_t3");
    nextCycle();
    checkQuiet("reset_op2_t4");
    runOp(0, 4'd1, 32'h0000_0001, 32'h01FF_FFFF, RESP_OK, 32'h0200_0000, "add_after_reset");

    // move the pointer off port 0, then reset in the grant cycle
    runOp(2, 4'd1, 32'h1, 32'h1, RESP_OK, 32'h2, "ptr_move");
    nextCycle();
    applyStimulus(3, 4'd1, 32'h3);
    nextCycle();
    applyStimulus(3, 4'd0, 32'h4);
    nextCycle();
    idleAll();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkQuiet("reset_wait_t3");
    nextCycle();
    checkQuiet("reset_wait_t4");

    runBurst(0, "burst_after_reset");
    runBurst(0, "burst_wrapped");
    runOp(1, 4'd1, 32'h1, 32'h1, RESP_OK, 32'h2, "ptr_to_2");
    runBurst(2, "burst_from_2");

    // narrow build: overflow at 8 bits
    cmd8  = {4'd1, 4'd1};
    data8 = {8'h7F, 8'h80};
    nextCycle();
    cmd8  = '0;
    data8 = {8'h01, 8'h80};
    nextCycle();
    data8 = '0;
    nextCycle();
    check8("w8_add_ovf", 0, RESP_ERR, 8'h00);
    check8("w8_idle", 1, RESP_NONE, 8'h00);
    nextCycle();
    check8("w8_add_ok", 1, RESP_OK, 8'h80);
    check8("w8_idle", 0, RESP_NONE, 8'h00);

    // randomized traffic against a request-level model
    reset = 1'b1;
    idleAll();
    nextCycle();
    reset = 1'b0;
    rr = 0;
    for (int p = 0; p < NP; p++) begin
      busy[p] = 1'b0; op2_due[p] = 1'b0; ready[p] = 0;
      er[p] = RESP_NONE; ed[p] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      nextCycle();
      for (int p = 0; p < NP; p++) checkOutput("random", p, er[p], ed[p]);
      for (int p = 0; p < NP; p++) begin
        if (op2_due[p]) begin
          mb[p] = rndOp();
          applyStimulus(p, 4'($urandom % 16), mb[p]);
          op2_due[p] = 1'b0;
        end else if (busy[p]) begin
          applyStimulus(p, 4'($urandom % 16), DW'($urandom));
        end else if (c < 380 && ($urandom % 2) == 1) begin
          mc[p] = rndCmd();
          ma[p] = rndOp();
          applyStimulus(p, mc[p], ma[p]);
          busy[p] = 1'b1;
          op2_due[p] = 1'b1;
          ready[p] = c + 2;
        end else begin
          applyStimulus(p, 4'd0, DW'($urandom));
        end
      end
      for (int p = 0; p < NP; p++) begin
        er[p] = RESP_NONE;
        ed[p] = '0;
      end
      g = -1;
      for (int i = 0; i < NP; i++) begin
        q = (rr + i) % NP;
        if (g < 0 && busy[q] && ready[q] <= c) g = q;
      end
      if (g >= 0) begin
        refCalc(mc[g], ma[g], mb[g], er[g], ed[g]);
        busy[g] = 1'b0;
        rr = (g + 1) % NP;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
